crc_stream_engine: RTL and testbench

//  Parametrised, multi-byte CRC engine for framed data streams; successor to the fixed 8-bit bit-serial CRC-8 byte block.

---
 rtl/crc_pkg.sv | 28 ++
 rtl/crc_fold_step.sv | 29 ++
 rtl/crc_stream_engine.sv | 129 ++++++++++++
 tb/tb_crc_stream_engine.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/crc_pkg.sv
// Shared definitions for the CRC stream engine.
//  - FSM state encoding (2-bit)
//  - bitrev(): reverses the low w bits of a 32-bit word
//  - Named polynomial/init sets for common CRCs
package crc_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SHIFT = 2'd1;
  localparam state_t ST_DONE  = 2'd2;

  localparam logic [7:0]  CRC8_SMBUS_POLY  = 8'h07;
  localparam logic [7:0]  CRC8_SMBUS_INIT  = 8'h00;
  localparam logic [15:0] CRC16_CCITT_POLY = 16'h1021;
  localparam logic [15:0] CRC16_CCITT_INIT = 16'hFFFF;

  // Bit 0 of the result is bit w-1 of v; bits at and above w are zero.
  function automatic logic [31:0] bitrev(input logic [31:0] v, input int unsigned w);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < w) r[i] = v[w-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/crc_fold_step.sv
// Combinational fold of BITS bits into a CRC register.
//  crc_in   : current register value
//  bits_in  : bits to fold; bits_in[BITS-1] is folded first
//  crc_next : register after all BITS bits have been folded
module crc_fold_step #(
  parameter int               CRC_W = 8,
  parameter logic [CRC_W-1:0] POLY  = 8'h07,
  parameter int               BITS  = 1
) (
  input  logic [CRC_W-1:0] crc_in,
  input  logic [BITS-1:0]  bits_in,
  output logic [CRC_W-1:0] crc_next
);

  logic [CRC_W-1:0] c;
  logic             fb;

  // NOTE: every variable written here gets a value before any branch, so no latch is inferred.
  always_comb begin
    c  = crc_in;
    fb = 1'b0;
    for (int i = BITS - 1; i >= 0; i--) begin
      fb = c[CRC_W-1] ^ bits_in[i];
      c  = (c << 1) ^ (fb ? POLY : '0);
    end
    crc_next = c;
  end

endmodule

// File: rtl/crc_stream_engine.sv
// Parametrised CRC engine for framed byte/word streams.
//  clk, rst_n (sync, active-low), clr (sync frame abort)
//  in_data/in_valid/in_last/in_ready : beat input handshake
//  crc_out/crc_ok/crc_valid/out_ready: frame result handshake
//  busy : a frame is in progress (beat accepted, result not yet taken)
// Each accepted beat is folded BITS_PER_CYCLE bits per clock over
// STEPS = DATA_W/BITS_PER_CYCLE clocks; the register carries across beats
// until the frame's result is taken, cleared, or reset.
module crc_stream_engine
  import crc_pkg::*;
#(
  parameter int               CRC_W          = 8,
  parameter logic [CRC_W-1:0] POLY           = 8'h07,
  parameter logic [CRC_W-1:0] INIT           = 8'h00,
  parameter logic [CRC_W-1:0] XOR_OUT        = 8'h00,
  parameter int               DATA_W         = 8,
  parameter int               BITS_PER_CYCLE = 1,
  parameter bit               REFLECT_IN     = 1'b0,
  parameter bit               REFLECT_OUT    = 1'b0,
  parameter logic [CRC_W-1:0] RESIDUE        = 8'h00
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [CRC_W-1:0]  crc_out,
  output logic              crc_ok,
  output logic              crc_valid,
  input  logic              out_ready,
  output logic              busy
);

  localparam int STEPS = DATA_W / BITS_PER_CYCLE;
  localparam int SW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [SW-1:0] LAST_STEP = SW'(STEPS - 1);

  state_t                    state, state_nx;
  logic [CRC_W-1:0]          crc_reg, crc_fold, crc_reg_rev;
  logic [DATA_W-1:0]         data_q, data_ord;
  logic [SW-1:0]             step_cnt;
  logic                      last_q;
  logic                      accept, step_end;
  logic [BITS_PER_CYCLE-1:0] chunk;

  assign accept   = in_valid && in_ready;
  assign step_end = (step_cnt == LAST_STEP);

  // data_q is always stored MSB-first so the fold can take the top chunk.
  always_comb begin
    for (int i = 0; i < DATA_W; i++) begin
      data_ord[i] = REFLECT_IN ? in_data[DATA_W-1-i] : in_data[i];
    end
  end

  assign chunk = data_q[DATA_W-1 -: BITS_PER_CYCLE];

  crc_fold_step #(
    .CRC_W (CRC_W),
    .POLY  (POLY),
    .BITS  (BITS_PER_CYCLE)
  ) u_fold (
    .crc_in   (crc_reg),
    .bits_in  (chunk),
    .crc_next (crc_fold)
  );

  // NOTE: reset is synchronous -- sampled only on the clock edge, never in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) state <= ST_IDLE;
    else               state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (accept)    state_nx = ST_SHIFT;
      ST_SHIFT: if (step_end)  state_nx = last_q ? ST_DONE : ST_IDLE;
      ST_DONE:  if (out_ready) state_nx = ST_IDLE;
      default:                 state_nx = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      crc_reg  <= INIT;
      step_cnt <= '0;
      last_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            last_q   <= in_last;
            step_cnt <= '0;
          end
        end
        ST_SHIFT: begin
          crc_reg  <= crc_fold;
          step_cnt <= step_end ? '0 : step_cnt + SW'(1);
        end
        ST_DONE: begin
          if (out_ready) crc_reg <= INIT;
        end
        default: ;
      endcase
    end
  end

  // NOTE: the beat buffer has no reset; it is always loaded on accept before it is read.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && accept) data_q <= data_ord;
    else if (state == ST_SHIFT)     data_q <= data_q << BITS_PER_CYCLE;
  end

  assign crc_reg_rev = CRC_W'(bitrev(32'(crc_reg), CRC_W));

  // Outputs are gated by rst_n so they read as idle during the reset cycle itself.
  always_comb begin
    in_ready  = rst_n && (state == ST_IDLE) && !clr;
    crc_valid = rst_n && (state == ST_DONE);
    busy      = rst_n && ((state != ST_IDLE) || (crc_reg != INIT));
    crc_out   = (REFLECT_OUT ? crc_reg_rev : crc_reg) ^ XOR_OUT;
    crc_ok    = crc_valid && (crc_reg == RESIDUE);
  end

endmodule

// File: tb/tb_crc_stream_engine.sv
// Self-checking bench for crc_stream_engine: three configurations
//  u0: defaults (CRC-8/SMBUS, bit-serial)
//  u1: CRC-16/CCITT-FALSE, 4 bits per clock
//  u2: reflected CRC-8 (poly 0x1D, init/xorout 0xFF), 2 bits per clock
// Results are compared against a message-level polynomial-division model.
module tb_crc_stream_engine;

  typedef logic [7:0] q8_t[$];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       clr[3], in_valid[3], in_last[3], out_ready[3];
  logic [7:0] in_data[3];
  logic       in_ready[3], crc_ok[3], crc_valid[3], busy[3];
  logic [7:0]  co0, co2;
  logic [15:0] co1;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          cfg_w[3]      = '{8, 16, 8};
  logic [15:0] cfg_poly[3]   = '{16'h0007, 16'h1021, 16'h001D};
  logic [15:0] cfg_init[3]   = '{16'h0000, 16'hFFFF, 16'h00FF};
  logic [15:0] cfg_xo[3]     = '{16'h0000, 16'h0000, 16'h00FF};
  logic [15:0] cfg_res[3]    = '{16'h0000, 16'h0000, 16'h0000};
  bit          cfg_refin[3]  = '{1'b0, 1'b0, 1'b1};
  bit          cfg_refout[3] = '{1'b0, 1'b0, 1'b1};
  int          cfg_steps[3]  = '{8, 2, 4};

  crc_stream_engine u0 (
    .clk(clk), .rst_n(rst_n), .clr(clr[0]), .in_data(in_data[0]), .in_valid(in_valid[0]),
    .in_last(in_last[0]), .in_ready(in_ready[0]), .crc_out(co0), .crc_ok(crc_ok[0]),
    .crc_valid(crc_valid[0]), .out_ready(out_ready[0]), .busy(busy[0])
  );

  crc_stream_engine #(
    .CRC_W(16), .POLY(16'h1021), .INIT(16'hFFFF), .XOR_OUT(16'h0000), .DATA_W(8),
    .BITS_PER_CYCLE(4), .REFLECT_IN(1'b0), .REFLECT_OUT(1'b0), .RESIDUE(16'h0000)
  ) u1 (
    .clk(clk), .rst_n(rst_n), .clr(clr[1]), .in_data(in_data[1]), .in_valid(in_valid[1]),
    .in_last(in_last[1]), .in_ready(in_ready[1]), .crc_out(co1), .crc_ok(crc_ok[1]),
    .crc_valid(crc_valid[1]), .out_ready(out_ready[1]), .busy(busy[1])
  );

  crc_stream_engine #(
    .CRC_W(8), .POLY(8'h1D), .INIT(8'hFF), .XOR_OUT(8'hFF), .DATA_W(8),
    .BITS_PER_CYCLE(2), .REFLECT_IN(1'b1), .REFLECT_OUT(1'b1), .RESIDUE(8'h00)
  ) u2 (
    .clk(clk), .rst_n(rst_n), .clr(clr[2]), .in_data(in_data[2]), .in_valid(in_valid[2]),
    .in_last(in_last[2]), .in_ready(in_ready[2]), .crc_out(co2), .crc_ok(crc_ok[2]),
    .crc_valid(crc_valid[2]), .out_ready(out_ready[2]), .busy(busy[2])
  );

  function automatic logic [15:0] obs_out(input int u);
    case (u)
      0:       return {8'h00, co0};
      1:       return co1;
      default: return {8'h00, co2};
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Polynomial long division of the message bit stream, one bit at a time.
  task automatic model(input int u, input q8_t msg, output logic [15:0] eo, output logic eok);
    int          cw;
    logic [15:0] r, rev, mask;
    logic        b, top;
    cw   = cfg_w[u];
    mask = (cw == 16) ? 16'hFFFF : ((16'd1 << cw) - 16'd1);
    r    = cfg_init[u];
    foreach (msg[n]) begin
      for (int i = 0; i < 8; i++) begin
        b   = cfg_refin[u] ? msg[n][i] : msg[n][7-i];
        top = r[cw-1];
        r   = (r << 1) & mask;
        if (top ^ b) r = r ^ cfg_poly[u];
      end
    end
    rev = '0;
    for (int i = 0; i < cw; i++) rev[i] = r[cw-1-i];
    eok = (r == cfg_res[u]);
    eo  = (cfg_refout[u] ? rev : r) ^ cfg_xo[u];
  endtask

  // Sends msg beat by beat, checks beat spacing and the result, holds the
  // result for `hold` cycles, then takes it when `take` is set.
  task automatic run_frame(input int u, input q8_t msg, input int hold, input bit take,
                           input int known);
    int          t_prev;
    logic [15:0] eo;
    logic        eok;
    bit          got;
    model(u, msg, eo, eok);
    t_prev = -1;
    foreach (msg[n]) begin
      got = 1'b0;
      for (int w = 0; w < 100 && !got; w++) begin
        @(negedge clk);
        got = in_ready[u];
      end
      if (n == 0) check($sformatf("u%0d_ready", u), got, 1);
      in_data[u]  = msg[n];
      in_valid[u] = 1'b1;
      in_last[u]  = (n == msg.size() - 1);
      @(posedge clk);
      #1;
      in_valid[u] = 1'b0;
      in_last[u]  = 1'b0;
      if (t_prev >= 0) check($sformatf("u%0d_gap", u), cyc - t_prev, cfg_steps[u] + 1);
      t_prev = cyc;
    end
    got = 1'b0;
    for (int w = 0; w < 400 && !got; w++) begin
      @(negedge clk);
      got = crc_valid[u];
    end
    check($sformatf("u%0d_valid", u), got, 1);
    check($sformatf("u%0d_crc_out", u), obs_out(u), eo);
    check($sformatf("u%0d_crc_ok", u), crc_ok[u], eok);
    if (known >= 0) check($sformatf("u%0d_known", u), obs_out(u), known);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check($sformatf("u%0d_hold_valid", u), crc_valid[u], 1);
      check($sformatf("u%0d_hold_out", u), obs_out(u), eo);
      check($sformatf("u%0d_hold_ready", u), in_ready[u], 0);
    end
    if (take) begin
      out_ready[u] = 1'b1;
      @(posedge clk);
      #1;
      out_ready[u] = 1'b0;
      @(negedge clk);
      check($sformatf("u%0d_valid_drop", u), crc_valid[u], 0);
    end
  endtask

  initial begin
    q8_t check_str, m;
    bit  seen;

    check_str = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    rst_n = 1'b0;
    for (int u = 0; u < 3; u++) begin
      clr[u] = 1'b0; in_valid[u] = 1'b0; in_last[u] = 1'b0;
      out_ready[u] = 1'b0; in_data[u] = 8'h00;
    end

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      check($sformatf("rst_ready_u%0d", u), in_ready[u], 0);
      check($sformatf("rst_valid_u%0d", u), crc_valid[u], 0);
      check($sformatf("rst_busy_u%0d", u), busy[u], 0);
    end
    rst_n = 1'b1;

    // 1: CRC-8 check string, bit serial
    run_frame(0, check_str, 0, 1'b1, 'hF4);

    // 2: residue check, good and corrupted
    m = check_str;
    m.push_back(8'hF4);
    run_frame(0, m, 0, 1'b1, 'h00);
    check("residue_ok", crc_ok[0], 0);  // crc_valid already dropped, ok is gated off
    m[2] = m[2] ^ 8'h04;
    run_frame(0, m, 0, 1'b1, -1);

    // 3: CRC-16/CCITT-FALSE, 4 bits per clock
    run_frame(1, check_str, 0, 1'b1, 'h29B1);

    // 4: backpressure, then a single beat 0x01
    run_frame(0, '{8'h5A}, 5, 1'b1, -1);
    run_frame(0, '{8'h01}, 0, 1'b1, 'h07);

    // 5: clr in the middle of the 4th beat of a frame
    for (int n = 0; n < 4; n++) begin
      seen = 1'b0;
      for (int w = 0; w < 100 && !seen; w++) begin
        @(negedge clk);
        seen = in_ready[0];
      end
      in_data[0] = check_str[n]; in_valid[0] = 1'b1; in_last[0] = (n == 3);
      @(posedge clk);
      #1;
      in_valid[0] = 1'b0; in_last[0] = 1'b0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    clr[0] = 1'b1;
    #1;
    check("clr_ready_low", in_ready[0], 0);
    @(posedge clk);
    #1;
    clr[0] = 1'b0;
    seen = 1'b0;
    for (int w = 0; w < 20; w++) begin
      @(negedge clk);
      if (crc_valid[0]) seen = 1'b1;
    end
    check("clr_no_valid", seen, 0);
    check("clr_busy", busy[0], 0);
    run_frame(0, '{8'h00}, 0, 1'b1, 'h00);

    // Randomised frames on every configuration
    for (int u = 0; u < 3; u++) begin
      for (int f = 0; f < 6; f++) begin
        m = {};
        for (int n = 0; n < $urandom_range(1, 5); n++) m.push_back(8'($urandom));
        run_frame(u, m, $urandom_range(0, 3), 1'b1, -1);
      end
    end

    // 6: reset while a result is waiting
    run_frame(0, '{8'h42}, 0, 1'b0, -1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_done_valid", crc_valid[0], 0);
    check("rst_done_ready", in_ready[0], 0);
    @(posedge clk);
    @(negedge clk);
    check("rst_hold_valid", crc_valid[0], 0);
    check("rst_hold_busy", busy[0], 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_after_ready", in_ready[0], 1);
    check("rst_after_valid", crc_valid[0], 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
